// File: rtl/fft_input_packer_pkg.sv
// Shared FFT datapath types and sizing, also used by shift_reg.
package fft_pkg;

   localparam int WIDTH          = 9;
   localparam int LANES          = 16;
   localparam int FRAME_LEN      = 512;
   localparam int VECS_PER_FRAME = FRAME_LEN / LANES;

   localparam int LANE_W = $clog2(LANES);
   localparam int VEC_W  = $clog2(VECS_PER_FRAME);

   typedef logic signed [WIDTH-1:0] sample_t;
   typedef sample_t [0:LANES-1]     lane_vec_t;

   // IDLE: nothing accepted yet in the current frame; FILL: frame in progress.
   typedef enum logic {
      IDLE,
      FILL
   } pack_state_t;

endpackage

// File: rtl/fft_input_packer_if.sv
// Sample-in / packed-vector-out bus of the FFT input packer.
interface fft_input_packer_if;
   import fft_pkg::*;

   logic      in_valid;
   sample_t   in_re;
   sample_t   in_im;
   logic      in_last;

   logic      valid;
   lane_vec_t dout_re;
   lane_vec_t dout_im;
   logic      frame_start;
   logic      frame_last;
   logic      short_frame;

   // master: sample producer / vector consumer side
   modport master (
      output in_valid, in_re, in_im, in_last,
      input  valid, dout_re, dout_im, frame_start, frame_last, short_frame
   );

   // slave: the packer itself
   modport slave (
      input  in_valid, in_re, in_im, in_last,
      output valid, dout_re, dout_im, frame_start, frame_last, short_frame
   );

endinterface

// File: rtl/fft_input_packer.sv
// Packs LANES consecutive complex samples into one vector with frame markers.
module fft_input_packer
   import fft_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   fft_input_packer_if.slave   bus
);

   localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(LANES - 1);
   localparam logic [VEC_W-1:0]  VEC_MAX  = VEC_W'(VECS_PER_FRAME - 1);

   pack_state_t       state_q, state_d;
   logic [LANE_W-1:0] lane_cnt;
   logic [VEC_W-1:0]  vec_cnt;
   lane_vec_t         stage_re, stage_im;
   lane_vec_t         pack_re, pack_im;
   logic              accept, emit, close_frame, short_now;

   // Emit / frame-close decisions for the current cycle
   always_comb begin
      accept      = bus.in_valid;
      emit        = accept && ((lane_cnt == LANE_MAX) || bus.in_last);
      close_frame = emit && ((vec_cnt == VEC_MAX) || bus.in_last);
      // Only a frame that ends exactly on its final lane of the final vector is full length
      short_now   = emit && bus.in_last && !((vec_cnt == VEC_MAX) && (lane_cnt == LANE_MAX));
   end

   // Assemble outgoing vector: staged lanes, current sample, zero padding above it
   always_comb begin
      pack_re = '0;
      pack_im = '0;
      for (int unsigned j = 0; j < LANES; j++) begin
         if (LANE_W'(j) < lane_cnt) begin
            pack_re[j] = stage_re[j];
            pack_im[j] = stage_im[j];
         end else if (LANE_W'(j) == lane_cnt) begin
            pack_re[j] = bus.in_re;
            pack_im[j] = bus.in_im;
         end
      end
   end

   // Frame FSM next-state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = close_frame ? IDLE : FILL;
         FILL:    if (close_frame) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Frame FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Staging, counters and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_cnt        <= '0;
         vec_cnt         <= '0;
         stage_re        <= '0;
         stage_im        <= '0;
         bus.valid       <= 1'b0;
         bus.dout_re     <= '0;
         bus.dout_im     <= '0;
         bus.frame_start <= 1'b0;
         bus.frame_last  <= 1'b0;
         bus.short_frame <= 1'b0;
      end else begin
         bus.valid <= emit;
         if (emit) begin
            bus.dout_re     <= pack_re;
            bus.dout_im     <= pack_im;
            bus.frame_start <= (vec_cnt == '0);
            bus.frame_last  <= close_frame;
            bus.short_frame <= short_now;
         end else begin
            bus.frame_start <= 1'b0;
            bus.frame_last  <= 1'b0;
            bus.short_frame <= 1'b0;
         end

         if (accept) begin
            stage_re[lane_cnt] <= bus.in_re;
            stage_im[lane_cnt] <= bus.in_im;
            if (emit) begin
               lane_cnt <= '0;
               vec_cnt  <= close_frame ? '0 : vec_cnt + 1'b1;
            end else begin
               lane_cnt <= lane_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fft_input_packer.sv
// Directed self-checking bench for fft_input_packer.
module tb_fft_input_packer;
   import fft_pkg::*;

   typedef struct {
      lane_vec_t re;
      lane_vec_t im;
      logic      fs;
      logic      fl;
      logic      sf;
      int        cyc;
   } vec_rec_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   acc [0:1023];
   vec_rec_t q [$];
   vec_rec_t mon_rec;

   fft_input_packer_if bus ();

   fft_input_packer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Capture every emitted vector away from the active edge
   always @(negedge clk) begin
      if (bus.valid === 1'b1) begin
         mon_rec.re  = bus.dout_re;
         mon_rec.im  = bus.dout_im;
         mon_rec.fs  = bus.frame_start;
         mon_rec.fl  = bus.frame_last;
         mon_rec.sf  = bus.short_frame;
         mon_rec.cyc = cyc;
         q.push_back(mon_rec);
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Value of v as it appears after truncation to a WIDTH-bit signed sample
   function automatic int sx(input int v);
      sample_t t;
      t = sample_t'(v);
      return int'(t);
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_re    = '0;
      bus.in_im    = '0;
      idle(2);
      rst = 1'b0;
      q.delete();
   endtask

   task automatic send(input int n, input int re, input int im, input bit last);
      bus.in_valid = 1'b1;
      bus.in_re    = sample_t'(re);
      bus.in_im    = sample_t'(im);
      bus.in_last  = last;
      @(posedge clk);
      #1;
      acc[n]       = cyc;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic check_flags(input string tag, input int k, input int fs, input int fl, input int sf);
      check($sformatf("%s_fs%0d", tag, k), int'(q[k].fs), fs);
      check($sformatf("%s_fl%0d", tag, k), int'(q[k].fl), fl);
      check($sformatf("%s_sf%0d", tag, k), int'(q[k].sf), sf);
   endtask

   // Lanes of vector k hold base+j for j < nval and zero above
   task automatic check_ramp(input string tag, input int k, input int base, input int nval);
      for (int j = 0; j < LANES; j++) begin
         check($sformatf("%s_re%0d_%0d", tag, k, j), int'(q[k].re[j]), (j < nval) ? sx(base + j) : 0);
         check($sformatf("%s_im%0d_%0d", tag, k, j), int'(q[k].im[j]), (j < nval) ? sx(-(base + j)) : 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_re    = '0;
      bus.in_im    = '0;
      idle(1);
      check("rst_valid", int'(bus.valid), 0);
      check("rst_fs", int'(bus.frame_start), 0);
      check("rst_fl", int'(bus.frame_last), 0);
      check("rst_sf", int'(bus.short_frame), 0);
      check("rst_re0", int'(bus.dout_re[0]), 0);
      check("rst_re15", int'(bus.dout_re[15]), 0);
      check("rst_im0", int'(bus.dout_im[0]), 0);
      rst = 1'b0;
      q.delete();

      // Full frame, contiguous
      do_reset();
      for (int n = 0; n < FRAME_LEN; n++) send(n, n, -n, n == FRAME_LEN - 1);
      idle(3);
      check("ff_count", q.size(), 32);
      for (int k = 0; k < q.size() && k < 32; k++) begin
         check_ramp("ff", k, 16 * k, 16);
         check_flags("ff", k, k == 0, k == 31, 0);
      end
      if (q.size() > 0) check("ff_latency", q[0].cyc, acc[15]);

      // Gapped input
      do_reset();
      for (int n = 0; n < FRAME_LEN; n++) begin
         send(n, n, -n, n == FRAME_LEN - 1);
         idle(1);
      end
      idle(3);
      check("gap_count", q.size(), 32);
      for (int k = 0; k < q.size() && k < 32; k++) begin
         check_ramp("gap", k, 16 * k, 16);
         check_flags("gap", k, k == 0, k == 31, 0);
         check($sformatf("gap_lat%0d", k), q[k].cyc, acc[16 * k + 15]);
         if (k > 0) check($sformatf("gap_space%0d", k), q[k].cyc - q[k - 1].cyc, 32);
      end

      // Short frame of 21 samples
      do_reset();
      for (int n = 0; n < 21; n++) send(n, n, -n, n == 20);
      idle(3);
      check("sh_count", q.size(), 2);
      if (q.size() >= 2) begin
         check_ramp("sh", 0, 0, 16);
         check_flags("sh", 0, 1, 0, 0);
         check_ramp("sh", 1, 16, 5);
         check_flags("sh", 1, 0, 1, 1);
      end
      // Single-sample frame straight from IDLE
      q.delete();
      send(0, 7, -7, 1'b1);
      idle(3);
      check("one_count", q.size(), 1);
      if (q.size() >= 1) begin
         check_ramp("one", 0, 7, 1);
         check_flags("one", 0, 1, 1, 1);
      end
      // Following group starts a fresh frame
      q.delete();
      for (int n = 0; n < 16; n++) send(n, 30 + n, -(30 + n), 1'b0);
      idle(3);
      check("nxt_count", q.size(), 1);
      if (q.size() >= 1) begin
         check_ramp("nxt", 0, 30, 16);
         check_flags("nxt", 0, 1, 0, 0);
      end

      // in_last on the final lane of vector 1: short frame
      do_reset();
      for (int n = 0; n < 32; n++) send(n, n, -n, n == 31);
      idle(3);
      check("l15_count", q.size(), 2);
      if (q.size() >= 2) begin
         check_flags("l15", 0, 1, 0, 0);
         check_flags("l15", 1, 0, 1, 1);
         check_ramp("l15", 1, 16, 16);
      end

      // Reset in the middle of a group
      do_reset();
      for (int n = 0; n < 8; n++) send(n, 50 + n, -(50 + n), 1'b0);
      idle(2);
      check("mid_pre_count", q.size(), 0);
      rst = 1'b1;
      #2;
      check("mid_rst_valid", int'(bus.valid), 0);
      idle(1);
      rst = 1'b0;
      for (int n = 0; n < 16; n++) send(n, 100 + n, -(100 + n), 1'b0);
      idle(3);
      check("mid_count", q.size(), 1);
      if (q.size() >= 1) begin
         check_ramp("mid", 0, 100, 16);
         check_flags("mid", 0, 1, 0, 0);
      end

      // Extreme component values
      q.delete();
      for (int n = 0; n < 16; n++) send(n, -256, 255, 1'b0);
      idle(3);
      check("ext_count", q.size(), 1);
      if (q.size() >= 1) begin
         for (int j = 0; j < LANES; j++) begin
            check($sformatf("ext_re%0d", j), int'(q[0].re[j]), -256);
            check($sformatf("ext_im%0d", j), int'(q[0].im[j]), 255);
         end
      end

      // Back-to-back frames, natural wrap
      do_reset();
      for (int n = 0; n < 1024; n++) send(n, n, -n, 1'b0);
      idle(3);
      check("b2b_count", q.size(), 64);
      for (int k = 0; k < q.size() && k < 64; k++) begin
         check_flags("b2b", k, (k == 0) || (k == 32), (k == 31) || (k == 63), 0);
         check($sformatf("b2b_re0_%0d", k), int'(q[k].re[0]), sx(16 * k));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fft_input_packer.md
Name: fft_input_packer

Overview:
- Writer-side front end of the 512-point FFT datapath.
- Accepts one complex sample per clock and packs 16 consecutive samples into a parallel lane vector.
- Emits each vector with a one-cycle valid strobe, in the exact format shift_reg consumes (32 vectors per 512-sample frame).
- Also marks frame boundaries and pads short frames.

Parameters:
- WIDTH, 9, signed bit width of each real/imag component
- LANES, 16, samples per output vector
- FRAME_LEN, 512, samples per FFT frame; must be a multiple of LANES (32 vectors at default)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_re/in_im carry a sample this cycle
- in_re  input  WIDTH signed  real part of input sample
- in_im  input  WIDTH signed  imag part of input sample
- in_last  input  1  qualified by in_valid; this sample ends the frame
- valid  output  1  one-cycle strobe; dout vectors hold a new packed vector
- dout_re  output  [0:LANES-1] x WIDTH signed  packed real parts
- dout_im  output  [0:LANES-1] x WIDTH signed  packed imag parts
- frame_start  output  1  with valid: vector is vector 0 of a frame
- frame_last  output  1  with valid: vector is the final vector of a frame
- short_frame  output  1  with valid: frame ended by in_last before FRAME_LEN samples

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high. While rst is high, all state and outputs clear.
- Reset values: valid=0, frame_start=0, frame_last=0, short_frame=0, all dout lanes=0, lane_cnt=0, vec_cnt=0, state=IDLE.
- Lane order: lane j holds the j-th accepted sample of the group (lane 0 is the earliest). Data passes through unmodified; there is no arithmetic or saturation.
- Sample capture: a sample is accepted only when in_valid=1. It is written into staging lane lane_cnt, then lane_cnt increments.
- Gaps: in_valid=0 holds all counters and staging.
- Emit on full group: when lane_cnt=LANES-1 and a sample is accepted:
  - On the next edge the staging lanes plus the current sample are copied to dout_re/dout_im.
  - valid=1 for exactly one cycle. Latency is 1 cycle after the 16th accepted sample.
  - lane_cnt returns to 0 and vec_cnt increments.
- dout holds its last value between strobes. Consumers sample dout only when valid=1.
- frame_start=1 with valid when the emitted vector has vec_cnt=0. It is 0 otherwise.
- frame_last=1 with valid when vec_cnt=FRAME_LEN/LANES-1 or when the vector was closed by in_last. vec_cnt then returns to 0.
- Natural wrap: without in_last, frames wrap every FRAME_LEN samples. frame_last asserts on vector 31 and frame_start on the following vector.
- in_last with a partial group (lane_cnt<LANES-1):
  - Lanes above the last sample are zero-padded and the vector is emitted on the next edge.
  - frame_last=1; short_frame=1 if the total frame sample count is below FRAME_LEN.
  - Both counters then reset to 0.
- in_last on lane LANES-1: normal emit. short_frame=1 only if vec_cnt is not the last vector.
- in_last exactly at sample FRAME_LEN-1: normal frame_last, short_frame=0.
- FSM: IDLE (no samples accepted in current frame) and FILL (at least one sample accepted).
  - IDLE->FILL on an accepted sample.
  - FILL->IDLE on frame_last emission.
  - IDLE with in_last on the first sample: 1-sample short frame. The vector is emitted with frame_start=frame_last=short_frame=1.
- Reset mid-operation: the partial group is discarded; no vector is emitted for it. The first post-reset sample lands in lane 0 of vector 0.
- Staging lanes do not need clearing between groups. Padding zeros are applied at emit time.

Decomposition:
- Package fft_pkg holds WIDTH, LANES, FRAME_LEN, VECS_PER_FRAME=FRAME_LEN/LANES, typedef sample_t (logic signed [WIDTH-1:0]), and typedef lane_vec_t (sample_t [0:LANES-1]). shift_reg shares this package.
- Single module, no sub-module. The counters and two-state FSM are small enough to keep inline.

Test Plan:
- Full frame: reset, then 512 contiguous samples re=n, im=-n (n=0..511), in_last at n=511 -> expect the following:
  - 32 valid strobes, vector k lane j = (16k+j, -(16k+j)).
  - First strobe on the cycle after n=15.
  - frame_start only on k=0, frame_last only on k=31, short_frame never.
- Gapped input: same data with in_valid alternating 1/0 -> identical vectors. valid strobes every 32 cycles, never on a gap cycle.
- Short frame: 21 samples n=0..20 with in_last at n=20 -> two strobes as follows:
  - Vector 0: lanes 0..15.
  - Vector 1: lanes 0..4=16..20, lanes 5..15=0, frame_last=1, short_frame=1.
  - The next sample emits later with frame_start=1.
- Reset mid-group: 8 samples, rst pulse, then 16 samples m=100..115 -> no strobe before the reset; one vector with lanes 100..115 and frame_start=1.
- Extremes: re=-256, im=255 in all lanes -> output lanes exactly -256/255 with no sign corruption.
- Back-to-back: 1024 samples, no in_last -> frame_start at vectors 0 and 32, frame_last at vectors 31 and 63, short_frame never.
